// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary64 field positions, state encoding and NaN helpers
package fp_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int EXP_MSB    = 62;
   localparam int EXP_LSB    = 52;
   localparam int MAN_MSB    = 51;

   // Canonical quiet NaN reported when a packet holds no ordered value.
   localparam logic [DATA_WIDTH-1:0] QNAN_CANON = 64'h7FF8_0000_0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Exponent all ones with a non-zero mantissa.
   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
      return (&v[EXP_MSB:EXP_LSB]) && (|v[MAN_MSB:0]);
   endfunction

   // Signalling NaN: a NaN whose quiet bit (mantissa MSB) is clear.
   function automatic logic is_snan(input logic [DATA_WIDTH-1:0] v);
      return is_nan(v) && !v[MAN_MSB];
   endfunction

endpackage

// File: rtl/fp_total_lt.sv
// rtl/fp_total_lt.sv - sign-magnitude total-order less-than for binary64 (NaNs left to caller)
module fp_total_lt
   import fp_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  lt
);

   logic                  sign_a;
   logic                  sign_b;
   logic [DATA_WIDTH-2:0] mag_a;
   logic [DATA_WIDTH-2:0] mag_b;

   assign sign_a = a[DATA_WIDTH-1];
   assign sign_b = b[DATA_WIDTH-1];
   assign mag_a  = a[DATA_WIDTH-2:0];
   assign mag_b  = b[DATA_WIDTH-2:0];

   // Opposite signs: the negative one is smaller, which also orders -0 below +0.
   // Same sign: exponent|mantissa compares as an unsigned magnitude, reversed when negative.
   always_comb begin
      lt = 1'b0;
      if (sign_a != sign_b) begin
         lt = sign_a;
      end else if (!sign_a) begin
         lt = (mag_a < mag_b);
      end else begin
         lt = (mag_a > mag_b);
      end
   end

endmodule

// File: rtl/fp_minmax_stream.sv
// rtl/fp_minmax_stream.sv - streaming binary64 min/max reduction with indices, count and flags
module fp_minmax_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_min,
   output logic [DATA_WIDTH-1:0] out_max,
   output logic [CNT_WIDTH-1:0]  out_min_idx,
   output logic [CNT_WIDTH-1:0]  out_max_idx,
   output logic [CNT_WIDTH-1:0]  out_count,
   output logic                  out_nv,
   output logic                  out_ovf
);

   import fp_pkg::*;

   state_t                state_q;
   state_t                state_d;

   logic [DATA_WIDTH-1:0] min_q;
   logic [DATA_WIDTH-1:0] max_q;
   logic [CNT_WIDTH-1:0]  min_idx_q;
   logic [CNT_WIDTH-1:0]  max_idx_q;
   logic [CNT_WIDTH-1:0]  count_q;
   logic                  nv_q;
   logic                  ovf_q;

   logic                  accept;
   logic                  data_nan;
   logic                  data_snan;
   logic                  min_nan;
   logic                  max_nan;
   logic                  lt_min;
   logic                  lt_max;
   logic                  take_min;
   logic                  take_max;
   logic                  count_sat;

   // in_data < running min
   fp_total_lt u_lt_min (
      .a  (in_data),
      .b  (min_q),
      .lt (lt_min)
   );

   // running max < in_data
   fp_total_lt u_lt_max (
      .a  (max_q),
      .b  (in_data),
      .lt (lt_max)
   );

   assign in_ready  = (state_q != ST_DONE) & ~in_rst;
   assign accept    = in_valid & in_ready;

   assign data_nan  = is_nan(in_data);
   assign data_snan = is_snan(in_data);
   assign min_nan   = is_nan(min_q);
   assign max_nan   = is_nan(max_q);
   assign count_sat = &count_q;

   // A NaN beat never displaces anything; an ordered beat always displaces a NaN
   // running value and otherwise only wins on a strict compare, so ties keep the earlier index.
   assign take_min  = !data_nan && (min_nan || lt_min);
   assign take_max  = !data_nan && (max_nan || lt_max);

   // State register.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and the result-valid strobe.
   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = in_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept && in_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Running min/max, indices, element count and sticky flags.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         min_q     <= '0;
         max_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         count_q   <= '0;
         nv_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         if (state_q == ST_IDLE) begin
            // First element seeds both extremes; a NaN seed is stored canonically so an
            // all-NaN packet reports the canonical qNaN at index 0.
            min_q     <= data_nan ? QNAN_CANON : in_data;
            max_q     <= data_nan ? QNAN_CANON : in_data;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= CNT_WIDTH'(1);
            nv_q      <= data_snan;
            ovf_q     <= 1'b0;
         end else begin
            // The pre-increment count is this element's index; once saturated every
            // later element reports the saturated value.
            if (take_min) begin
               min_q     <= in_data;
               min_idx_q <= count_q;
            end
            if (take_max) begin
               max_q     <= in_data;
               max_idx_q <= count_q;
            end
            if (count_sat) begin
               ovf_q <= 1'b1;
            end else begin
               count_q <= count_q + CNT_WIDTH'(1);
            end
            nv_q <= nv_q | data_snan;
         end
      end
   end

   assign out_min     = min_q;
   assign out_max     = max_q;
   assign out_min_idx = min_idx_q;
   assign out_max_idx = max_idx_q;
   assign out_count   = count_q;
   assign out_nv      = nv_q;
   assign out_ovf     = ovf_q;

endmodule

// File: tb/tb_fp_minmax_stream.sv
// tb/tb_fp_minmax_stream.sv - directed and randomized checks of fp_minmax_stream against a reference model
module tb_fp_minmax_stream;

   localparam logic [63:0] P_ZERO = 64'h0000_0000_0000_0000;
   localparam logic [63:0] N_ZERO = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONE    = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] N_TWO  = 64'hC000_0000_0000_0000;
   localparam logic [63:0] TWO    = 64'h4000_0000_0000_0000;
   localparam logic [63:0] F3_5   = 64'h400C_0000_0000_0000;
   localparam logic [63:0] N_FIVE = 64'hC014_0000_0000_0000;
   localparam logic [63:0] NINE   = 64'h4022_0000_0000_0000;
   localparam logic [63:0] SNAN   = 64'h7FF0_0000_0000_0001;
   localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] QNAN_P = 64'hFFF8_0000_0000_1234;

   typedef struct {
      logic [63:0] mn;
      logic [63:0] mx;
      int          mn_idx;
      int          mx_idx;
      int          cnt;
      bit          nv;
      bit          ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_ready;

   logic        in_ready16, out_valid16, out_nv16, out_ovf16;
   logic [63:0] out_min16, out_max16;
   logic [15:0] out_min_idx16, out_max_idx16, out_count16;

   logic        in_ready4, out_valid4, out_nv4, out_ovf4;
   logic [63:0] out_min4, out_max4;
   logic [3:0]  out_min_idx4, out_max_idx4, out_count4;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   fp_minmax_stream #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut16 (
      .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid16), .out_ready(out_ready),
      .out_min(out_min16), .out_max(out_max16), .out_min_idx(out_min_idx16),
      .out_max_idx(out_max_idx16), .out_count(out_count16), .out_nv(out_nv16), .out_ovf(out_ovf16)
   );

   fp_minmax_stream #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut4 (
      .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
      .out_min(out_min4), .out_max(out_max4), .out_min_idx(out_min_idx4),
      .out_max_idx(out_max_idx4), .out_count(out_count4), .out_nv(out_nv4), .out_ovf(out_ovf4)
   );

   // ---------------- reference model ----------------
   function automatic bit m_nan(input logic [63:0] v);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'h0);
   endfunction

   function automatic bit m_snan(input logic [63:0] v);
      return m_nan(v) && (v[51] == 1'b0);
   endfunction

   // Numeric order of two ordered values, with -0 placed below +0.
   function automatic bit m_before(input logic [63:0] a, input logic [63:0] b);
      real ra, rb;
      ra = $bitstoreal(a);
      rb = $bitstoreal(b);
      if (ra < rb) return 1'b1;
      if (ra > rb) return 1'b0;
      return (a[63] == 1'b1) && (b[63] == 1'b0);
   endfunction

   function automatic res_t model(input logic [63:0] q[$], input int sat);
      res_t r;
      int   imn = -1;
      int   imx = -1;
      r.nv = 1'b0;
      foreach (q[i]) begin
         if (m_snan(q[i])) r.nv = 1'b1;
         if (!m_nan(q[i])) begin
            if (imn < 0 || m_before(q[i], q[imn])) imn = i;
            if (imx < 0 || m_before(q[imx], q[i])) imx = i;
         end
      end
      if (imn < 0) begin
         r.mn = QNAN; r.mx = QNAN; r.mn_idx = 0; r.mx_idx = 0;
      end else begin
         r.mn = q[imn]; r.mx = q[imx];
         r.mn_idx = (imn > sat) ? sat : imn;
         r.mx_idx = (imx > sat) ? sat : imx;
      end
      r.cnt = (q.size() > sat) ? sat : q.size();
      r.ovf = (q.size() > sat);
      return r;
   endfunction

   function automatic logic [63:0] rand_val();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 11))
         0:  v = P_ZERO;
         1:  v = N_ZERO;
         2:  v = ONE;
         3:  v = N_TWO;
         4:  v = {v[63], 11'h7FF, 1'b1, v[50:0]};
         5:  v = {v[63], 11'h7FF, 1'b0, v[50:1], 1'b1};
         6:  v = {v[63], 63'h7FF0_0000_0000_0000};
         7:  v = {v[63], 11'h000, v[51:0]};
         default: if (v[62:52] == 11'h7FF) v[62] = 1'b0;
      endcase
      return v;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input res_t r16, input res_t r4);
      chk("valid16", {63'h0, out_valid16}, 64'h1);
      chk("min16", out_min16, r16.mn);
      chk("max16", out_max16, r16.mx);
      chk("min_idx16", {48'h0, out_min_idx16}, 64'(r16.mn_idx));
      chk("max_idx16", {48'h0, out_max_idx16}, 64'(r16.mx_idx));
      chk("count16", {48'h0, out_count16}, 64'(r16.cnt));
      chk("nv16", {63'h0, out_nv16}, {63'h0, r16.nv});
      chk("ovf16", {63'h0, out_ovf16}, {63'h0, r16.ovf});
      chk("ready16_done", {63'h0, in_ready16}, 64'h0);
      chk("valid4", {63'h0, out_valid4}, 64'h1);
      chk("min4", out_min4, r4.mn);
      chk("max4", out_max4, r4.mx);
      chk("min_idx4", {60'h0, out_min_idx4}, 64'(r4.mn_idx));
      chk("max_idx4", {60'h0, out_max_idx4}, 64'(r4.mx_idx));
      chk("count4", {60'h0, out_count4}, 64'(r4.cnt));
      chk("nv4", {63'h0, out_nv4}, {63'h0, r4.nv});
      chk("ovf4", {63'h0, out_ovf4}, {63'h0, r4.ovf});
      chk("ready4_done", {63'h0, in_ready4}, 64'h0);
   endtask

   task automatic chk_reset_state();
      chk("rst_valid16", {63'h0, out_valid16}, 64'h0);
      chk("rst_min16", out_min16, 64'h0);
      chk("rst_max16", out_max16, 64'h0);
      chk("rst_idx16", {32'h0, out_min_idx16, out_max_idx16}, 64'h0);
      chk("rst_count16", {48'h0, out_count16}, 64'h0);
      chk("rst_flags16", {62'h0, out_nv16, out_ovf16}, 64'h0);
      chk("rst_valid4", {63'h0, out_valid4}, 64'h0);
      chk("rst_min4", out_min4, 64'h0);
      chk("rst_max4", out_max4, 64'h0);
      chk("rst_idx_cnt4", {52'h0, out_min_idx4, out_max_idx4, out_count4}, 64'h0);
      chk("rst_flags4", {62'h0, out_nv4, out_ovf4}, 64'h0);
   endtask

   // Drive one element per beat, optionally with idle gaps; each beat is checked to be
   // offered while in_ready is high so it is taken on the next edge.
   task automatic send_beats(input logic [63:0] q[$], input bit mark_last, input bit gaps);
      int b;
      for (int i = 0; i < q.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = q[i];
         in_last  = mark_last && (i == q.size() - 1);
         b = 0;
         while (!in_ready16 && b < 20) begin
            @(posedge clk); #1;
            b++;
         end
         chk("ready16_beat", {63'h0, in_ready16}, 64'h1);
         chk("ready4_beat", {63'h0, in_ready4}, 64'h1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_packet(input logic [63:0] q[$], input int hold, input bit gaps);
      res_t r16, r4;
      r16 = model(q, 65535);
      r4  = model(q, 15);
      send_beats(q, 1'b1, gaps);
      chk_result(r16, r4);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk_result(r16, r4);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("released_valid16", {63'h0, out_valid16}, 64'h0);
      chk("released_ready16", {63'h0, in_ready16}, 64'h1);
      chk("released_valid4", {63'h0, out_valid4}, 64'h0);
   endtask

   task automatic pulse_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = NINE;
      in_last  = 1'b1;
      @(posedge clk); #1;
      chk("ready16_in_rst", {63'h0, in_ready16}, 64'h0);
      chk("ready4_in_rst", {63'h0, in_ready4}, 64'h0);
      @(posedge clk); #1;
      chk_reset_state();
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready16", {63'h0, in_ready16}, 64'h1);
      chk("post_rst_valid16", {63'h0, out_valid16}, 64'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] q[$];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("ready16_during_rst", {63'h0, in_ready16}, 64'h0);
      chk_reset_state();
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready16_after_rst", {63'h0, in_ready16}, 64'h1);
      chk("ready4_after_rst", {63'h0, in_ready4}, 64'h1);

      // Mixed signs.
      q = '{ONE, N_TWO, F3_5};
      run_packet(q, 0, 1'b0);
      // Signed zeros, then duplicates keeping the earlier index.
      q = '{P_ZERO, N_ZERO};
      run_packet(q, 0, 1'b0);
      q = '{ONE, ONE};
      run_packet(q, 1, 1'b0);
      q = '{TWO, ONE, TWO, ONE};
      run_packet(q, 0, 1'b0);
      // NaN handling.
      q = '{SNAN, ONE};
      run_packet(q, 0, 1'b0);
      q = '{QNAN_P, QNAN};
      run_packet(q, 0, 1'b0);
      q = '{ONE, SNAN, QNAN, N_TWO};
      run_packet(q, 0, 1'b0);
      // Single element.
      q = '{N_FIVE};
      run_packet(q, 0, 1'b0);
      // Backpressure held for five cycles, then back-to-back packet.
      q = '{F3_5, N_TWO};
      run_packet(q, 5, 1'b0);
      q = '{NINE};
      run_packet(q, 0, 1'b0);

      // Reset mid-packet after two beats, then a fresh single-element packet.
      q = '{N_FIVE, NINE};
      send_beats(q, 1'b0, 1'b0);
      pulse_reset();
      q = '{ONE};
      run_packet(q, 0, 1'b0);

      // Reset while a result is pending.
      q = '{TWO};
      send_beats(q, 1'b1, 1'b0);
      chk("pending_valid16", {63'h0, out_valid16}, 64'h1);
      pulse_reset();

      // Twenty elements: the 4-bit counter saturates, extremes sit beyond index 15.
      q.delete();
      for (int i = 0; i < 20; i++) q.push_back(ONE);
      q[17] = N_FIVE;
      q[18] = NINE;
      run_packet(q, 0, 1'b0);

      // Randomized packets with gaps and variable backpressure.
      for (int p = 0; p < 40; p++) begin
         q.delete();
         for (int i = 0; i < $urandom_range(1, 24); i++) q.push_back(rand_val());
         run_packet(q, $urandom_range(0, 3), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
